// File: rtl/rfphoenix_memreq_responder.sv
// rfphoenix_memreq_responder
// Far end of the core's memory request/response queue pair. Accepts one load/store
// request at a time, runs it as 128-bit classic bus cycles (four beats for a vector),
// then pushes a tagged response {rid, step, result, error} into a show-ahead FIFO.
//
// Ports
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*               request handshake and payload (func, size, address, data, tags)
//   cyc_o .. dat_o      bus master outputs (16-byte aligned address, lane selects)
//   ack_i, err_i, dat_i bus slave response
//   resp_*              FIFO head (valid/empty/fields) and pop strobe
module rfphoenix_memreq_responder #(
  parameter int unsigned RESP_DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         req_v_i,
  output logic         req_rdy_o,
  input  logic [1:0]   req_func_i,
  input  logic [1:0]   req_sz_i,
  input  logic [31:0]  req_adr_i,
  input  logic [511:0] req_dat_i,
  input  logic [3:0]   req_rid_i,
  input  logic [3:0]   req_step_i,
  output logic         cyc_o,
  output logic         stb_o,
  output logic         we_o,
  output logic [15:0]  sel_o,
  output logic [31:0]  adr_o,
  output logic [127:0] dat_o,
  input  logic         ack_i,
  input  logic         err_i,
  input  logic [127:0] dat_i,
  output logic         resp_v_o,
  output logic         resp_empty_o,
  input  logic         resp_rd_i,
  output logic [3:0]   resp_rid_o,
  output logic [3:0]   resp_step_o,
  output logic [511:0] resp_res_o,
  output logic         resp_err_o
);

  localparam int unsigned PtrW = $clog2(RESP_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] FuncLoad  = 2'd0;
  localparam logic [1:0] FuncStore = 2'd2;
  localparam logic [1:0] FuncRsvd  = 2'd3;
  localparam logic [1:0] SzByte    = 2'd0;
  localparam logic [1:0] SzWyde    = 2'd1;
  localparam logic [1:0] SzTetra   = 2'd2;
  localparam logic [1:0] SzVect    = 2'd3;

  // StGap holds the bus idle for one cycle between vector beats.
  typedef enum logic [1:0] {StIdle, StBus, StGap, StPush} state_e;

  state_e         state_q, state_d;
  logic [1:0]     beat_q, beat_d;
  logic [1:0]     func_q, func_d;
  logic [1:0]     sz_q, sz_d;
  logic [31:0]    adr_q, adr_d;
  logic [511:0]   dat_q, dat_d;
  logic [3:0]     rid_q, rid_d;
  logic [3:0]     step_q, step_d;
  logic [511:0]   res_q, res_d;
  logic           err_q, err_d;

  // Response FIFO
  logic [3:0]     mem_rid  [RESP_DEPTH];
  logic [3:0]     mem_step [RESP_DEPTH];
  logic [511:0]   mem_res  [RESP_DEPTH];
  logic           mem_err  [RESP_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] cnt_q;
  logic           push, pop, empty;

  logic           misaligned;
  logic [6:0]     shamt;
  logic [31:0]    lane;
  logic [31:0]    scalar_res;
  logic [15:0]    sel_raw;
  logic [127:0]   dat_raw;

  assign empty     = (cnt_q == '0);
  assign req_rdy_o = (state_q == StIdle) && (cnt_q < CntW'(RESP_DEPTH));
  assign push      = (state_q == StPush);
  assign pop       = resp_rd_i && !empty;

  always_comb begin
    misaligned = 1'b0;
    case (req_sz_i)
      SzWyde:  misaligned = req_adr_i[0];
      SzTetra: misaligned = |req_adr_i[1:0];
      SzVect:  misaligned = |req_adr_i[3:0];
      default: misaligned = 1'b0;
    endcase
  end

  // Lane extraction for scalar loads.
  assign shamt = {adr_q[3:0], 3'b000};
  assign lane  = 32'(dat_i >> shamt);

  always_comb begin
    scalar_res = '0;
    case (sz_q)
      SzByte:  scalar_res = (func_q == FuncLoad) ? {{24{lane[7]}}, lane[7:0]}
                                                 : {24'b0, lane[7:0]};
      SzWyde:  scalar_res = (func_q == FuncLoad) ? {{16{lane[15]}}, lane[15:0]}
                                                 : {16'b0, lane[15:0]};
      default: scalar_res = lane;
    endcase
  end

  always_comb begin
    sel_raw = 16'hFFFF;
    dat_raw = dat_q[{beat_q, 7'b0} +: 128];
    case (sz_q)
      SzByte:  begin sel_raw = 16'h0001 << adr_q[3:0]; dat_raw = {16{dat_q[7:0]}};  end
      SzWyde:  begin sel_raw = 16'h0003 << adr_q[3:0]; dat_raw = {8{dat_q[15:0]}};  end
      SzTetra: begin sel_raw = 16'h000F << adr_q[3:0]; dat_raw = {4{dat_q[31:0]}};  end
      default: ;
    endcase
  end

  // Bus outputs are zero outside an active cycle.
  assign cyc_o = (state_q == StBus);
  assign stb_o = cyc_o;
  assign we_o  = cyc_o && (func_q == FuncStore);
  assign sel_o = cyc_o ? sel_raw : '0;
  assign adr_o = cyc_o ? {adr_q[31:4] + 28'(beat_q), 4'h0} : '0;
  assign dat_o = cyc_o ? dat_raw : '0;

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    func_d  = func_q;
    sz_d    = sz_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rid_d   = rid_q;
    step_d  = step_q;
    res_d   = res_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_v_i && req_rdy_o) begin
          func_d = req_func_i;
          sz_d   = req_sz_i;
          adr_d  = req_adr_i;
          dat_d  = req_dat_i;
          rid_d  = req_rid_i;
          step_d = req_step_i;
          beat_d = '0;
          res_d  = '0;
          err_d  = 1'b0;
          if (misaligned || req_func_i == FuncRsvd) begin
            err_d   = 1'b1;
            state_d = StPush;
          end else begin
            state_d = StBus;
          end
        end
      end
      StBus: begin
        if (err_i) begin
          // Error wins over ack and abandons any remaining beats.
          err_d   = 1'b1;
          state_d = StPush;
        end else if (ack_i) begin
          if (func_q != FuncStore) begin
            if (sz_q == SzVect) res_d[{beat_q, 7'b0} +: 128] = dat_i;
            else                res_d = {480'b0, scalar_res};
          end
          if (sz_q == SzVect && beat_q != 2'd3) begin
            beat_d  = beat_q + 2'd1;
            state_d = StGap;
          end else begin
            state_d = StPush;
          end
        end
      end
      StGap:   state_d = StBus;
      StPush:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      beat_q  <= '0;
      func_q  <= '0;
      sz_q    <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rid_q   <= '0;
      step_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      func_q  <= func_d;
      sz_q    <= sz_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rid_q   <= rid_d;
      step_q  <= step_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  // FIFO storage needs no reset; pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_rid[wr_ptr_q]  <= rid_q;
      mem_step[wr_ptr_q] <= step_q;
      mem_res[wr_ptr_q]  <= res_q;
      mem_err[wr_ptr_q]  <= err_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CntW'(1);
        2'b01:   cnt_q <= cnt_q - CntW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign resp_empty_o = empty;
  assign resp_v_o     = !empty;
  assign resp_rid_o   = empty ? '0 : mem_rid[rd_ptr_q];
  assign resp_step_o  = empty ? '0 : mem_step[rd_ptr_q];
  assign resp_res_o   = empty ? '0 : mem_res[rd_ptr_q];
  assign resp_err_o   = empty ? 1'b0 : mem_err[rd_ptr_q];

endmodule

// File: tb/tb_rfphoenix_memreq_responder.sv
module tb_rfphoenix_memreq_responder;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_v, req_rdy;
  logic [1:0]   req_func, req_sz;
  logic [31:0]  req_adr;
  logic [511:0] req_dat;
  logic [3:0]   req_rid, req_step;
  logic         cyc, stb, we;
  logic [15:0]  sel;
  logic [31:0]  adr;
  logic [127:0] dat_o;
  logic         ack, err;
  logic [127:0] dat_i;
  logic         resp_v, resp_empty, resp_rd;
  logic [3:0]   resp_rid, resp_step;
  logic [511:0] resp_res;
  logic         resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rfphoenix_memreq_responder #(.RESP_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_v_i(req_v), .req_rdy_o(req_rdy), .req_func_i(req_func), .req_sz_i(req_sz),
    .req_adr_i(req_adr), .req_dat_i(req_dat), .req_rid_i(req_rid), .req_step_i(req_step),
    .cyc_o(cyc), .stb_o(stb), .we_o(we), .sel_o(sel), .adr_o(adr), .dat_o(dat_o),
    .ack_i(ack), .err_i(err), .dat_i(dat_i),
    .resp_v_o(resp_v), .resp_empty_o(resp_empty), .resp_rd_i(resp_rd),
    .resp_rid_o(resp_rid), .resp_step_o(resp_step), .resp_res_o(resp_res),
    .resp_err_o(resp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns #1 after the accepting edge.
  task automatic send_req(input logic [1:0] f, input logic [1:0] s, input logic [31:0] a,
                          input logic [511:0] d, input logic [3:0] r, input logic [3:0] st);
    int n = 0;
    req_v = 1'b1; req_func = f; req_sz = s; req_adr = a; req_dat = d;
    req_rid = r; req_step = st;
    while (req_rdy !== 1'b1 && n < 50) begin tick(); n++; end
    checks++;
    if (req_rdy !== 1'b1) begin
      errors++; $display("FAIL req_accept got rdy=%b want 1", req_rdy);
    end
    tick();
    req_v = 1'b0;
  endtask

  task automatic pop();
    resp_rd = 1'b1;
    tick();
    resp_rd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++;
    if (cyc !== 0 || stb !== 0 || we !== 0 || sel !== 0 || adr !== 0 || dat_o !== 0) begin
      errors++; $display("FAIL reset_bus got cyc=%b stb=%b we=%b sel=%h adr=%h want all 0",
                         cyc, stb, we, sel, adr);
    end
    checks++;
    if (resp_empty !== 1 || resp_v !== 0 || resp_rid !== 0 || resp_res !== 0 || resp_err !== 0)
    begin
      errors++; $display("FAIL reset_fifo got empty=%b v=%b rid=%h err=%b want 1 0 0 0",
                         resp_empty, resp_v, resp_rid, resp_err);
    end
    checks++;
    if (req_rdy !== 1) begin errors++; $display("FAIL reset_rdy got %b want 1", req_rdy); end
    // Stray ack/err with no cycle active must be ignored.
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    tick();
    checks++;
    if (resp_empty !== 1 || req_rdy !== 1) begin
      errors++; $display("FAIL stray_ack got empty=%b rdy=%b want 1 1", resp_empty, req_rdy);
    end
  endtask

  task automatic test_byte_load();
    send_req(2'd0, 2'd0, 32'h103, '0, 4'd1, 4'd2);
    checks++;
    if (cyc !== 1 || stb !== 1 || we !== 0 || sel !== 16'h0008 || adr !== 32'h100) begin
      errors++; $display("FAIL t1_bus got cyc=%b we=%b sel=%h adr=%h want 1 0 0008 100",
                         cyc, we, sel, adr);
    end
    tick();
    checks++;
    if (cyc !== 1) begin errors++; $display("FAIL t1_hold got cyc=%b want 1", cyc); end
    dat_i = 128'h80 << 24;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    checks++;
    if (cyc !== 0 || resp_v !== 0) begin
      errors++; $display("FAIL t1_latA1 got cyc=%b v=%b want 0 0", cyc, resp_v);
    end
    tick();
    checks++;
    if (resp_v !== 1 || resp_res !== 512'hFFFFFF80 || resp_err !== 0 ||
        resp_rid !== 4'd1 || resp_step !== 4'd2) begin
      errors++; $display("FAIL t1_resp got v=%b res=%h err=%b rid=%h step=%h want 1 ffffff80 0 1 2",
                         resp_v, resp_res[63:0], resp_err, resp_rid, resp_step);
    end
    pop();
    checks++;
    if (resp_empty !== 1) begin errors++; $display("FAIL t1_pop got empty=%b want 1", resp_empty); end
  endtask

  task automatic test_wyde_load();
    logic [1:0]   f   [2] = '{2'd1, 2'd0};
    logic [511:0] exp [2] = '{512'h00008001, 512'hFFFF8001};
    for (int i = 0; i < 2; i++) begin
      send_req(f[i], 2'd1, 32'h22, '0, 4'd3, 4'd0);
      checks++;
      if (sel !== 16'h000C || adr !== 32'h20) begin
        errors++; $display("FAIL t2_bus%0d got sel=%h adr=%h want 000c 20", i, sel, adr);
      end
      dat_i = 128'h8001 << 16;
      ack = 1'b1;
      tick();
      ack = 1'b0;
      tick();
      checks++;
      if (resp_res !== exp[i] || resp_err !== 0) begin
        errors++; $display("FAIL t2_res%0d got res=%h err=%b want %h 0",
                           i, resp_res[63:0], resp_err, exp[i][63:0]);
      end
      pop();
    end
  endtask

  task automatic test_store_err();
    send_req(2'd2, 2'd2, 32'h108, 512'h12345678, 4'd6, 4'd9);
    checks++;
    if (we !== 1 || sel !== 16'h0F00 || adr !== 32'h100 || dat_o !== {4{32'h12345678}}) begin
      errors++; $display("FAIL ts_bus got we=%b sel=%h adr=%h dat=%h want 1 0f00 100 rep",
                         we, sel, adr, dat_o);
    end
    ack = 1'b1; err = 1'b1;
    tick();
    ack = 1'b0; err = 1'b0;
    tick();
    checks++;
    if (resp_v !== 1 || resp_err !== 1 || resp_res !== 0 || resp_step !== 4'd9) begin
      errors++; $display("FAIL ts_resp got v=%b err=%b step=%h want 1 1 9",
                         resp_v, resp_err, resp_step);
    end
    pop();
  endtask

  task automatic test_vect_store();
    logic [511:0] d;
    for (int b = 0; b < 4; b++) d[128*b +: 128] = {96'h0, 32'hCAFE0000 + 32'(b)};
    send_req(2'd2, 2'd3, 32'h1000, d, 4'd5, 4'd1);
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (cyc !== 1 || we !== 1 || sel !== 16'hFFFF || adr !== 32'h1000 + 32'(16 * b) ||
          dat_o !== d[128*b +: 128]) begin
        errors++; $display("FAIL t3_beat%0d got cyc=%b we=%b sel=%h adr=%h dat=%h",
                           b, cyc, we, sel, adr, dat_o);
      end
      ack = 1'b1;
      tick();
      ack = 1'b0;
      if (b < 3) begin
        checks++;
        if (cyc !== 0) begin errors++; $display("FAIL t3_gap%0d got cyc=%b want 0", b, cyc); end
        tick();
      end
    end
    tick();
    checks++;
    if (resp_v !== 1 || resp_rid !== 4'd5 || resp_err !== 0 || resp_res !== 0) begin
      errors++; $display("FAIL t3_resp got v=%b rid=%h err=%b want 1 5 0",
                         resp_v, resp_rid, resp_err);
    end
    pop();
  endtask

  task automatic test_misaligned();
    send_req(2'd0, 2'd2, 32'h2, '0, 4'd8, 4'd0);
    checks++;
    if (cyc !== 0 || resp_v !== 0) begin
      errors++; $display("FAIL t4_t1 got cyc=%b v=%b want 0 0", cyc, resp_v);
    end
    tick();
    checks++;
    if (cyc !== 0 || resp_v !== 1 || resp_err !== 1 || resp_res !== 0 || resp_rid !== 4'd8) begin
      errors++; $display("FAIL t4_resp got cyc=%b v=%b err=%b rid=%h want 0 1 1 8",
                         cyc, resp_v, resp_err, resp_rid);
    end
    pop();
  endtask

  task automatic test_vect_err();
    logic [127:0] d0 = 128'h0011223344556677_8899AABBCCDDEEFF;
    logic [127:0] d1 = 128'hF0E1D2C3B4A59687_78695A4B3C2D1E0F;
    logic [511:0] exp = '0;
    exp[127:0]   = d0;
    exp[255:128] = d1;
    send_req(2'd0, 2'd3, 32'h2000, '0, 4'd2, 4'd7);
    for (int b = 0; b < 3; b++) begin
      checks++;
      if (cyc !== 1 || adr !== 32'h2000 + 32'(16 * b)) begin
        errors++; $display("FAIL t5_beat%0d got cyc=%b adr=%h", b, cyc, adr);
      end
      dat_i = (b == 0) ? d0 : (b == 1) ? d1 : '1;
      if (b == 2) err = 1'b1; else ack = 1'b1;
      tick();
      ack = 1'b0; err = 1'b0;
      if (b < 2) tick();
    end
    checks++;
    if (cyc !== 0) begin errors++; $display("FAIL t5_nobeat3 got cyc=%b want 0", cyc); end
    tick();
    checks++;
    if (cyc !== 0 || resp_v !== 1 || resp_err !== 1 || resp_res !== exp) begin
      errors++; $display("FAIL t5_resp got cyc=%b v=%b err=%b res_hi=%h res_lo=%h",
                         cyc, resp_v, resp_err, resp_res[511:256], resp_res[255:0]);
    end
    pop();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < 4; i++) begin
      send_req(2'd0, 2'd2, 32'h1, '0, 4'(i), 4'd0);
      tick();
    end
    checks++;
    if (req_rdy !== 0 || resp_v !== 1 || resp_rid !== 4'd0) begin
      errors++; $display("FAIL t6_full got rdy=%b v=%b rid=%h want 0 1 0", req_rdy, resp_v, resp_rid);
    end
    pop();
    checks++;
    if (req_rdy !== 1 || resp_rid !== 4'd1) begin
      errors++; $display("FAIL t6_pop1 got rdy=%b rid=%h want 1 1", req_rdy, resp_rid);
    end
    send_req(2'd0, 2'd2, 32'h1, '0, 4'd4, 4'd0);
    pop();  // lands on the push cycle
    checks++;
    if (resp_rid !== 4'd2 || req_rdy !== 1) begin
      errors++; $display("FAIL t6_pushpop got rid=%h rdy=%b want 2 1", resp_rid, req_rdy);
    end
    pop();
    checks++;
    if (resp_rid !== 4'd3) begin errors++; $display("FAIL t6_head3 got %h want 3", resp_rid); end
    pop();
    checks++;
    if (resp_rid !== 4'd4 || resp_v !== 1) begin
      errors++; $display("FAIL t6_head4 got rid=%h v=%b want 4 1", resp_rid, resp_v);
    end
    pop();
    checks++;
    if (resp_empty !== 1) begin errors++; $display("FAIL t6_drain got empty=%b want 1", resp_empty); end
  endtask

  task automatic test_reset_mid();
    send_req(2'd0, 2'd2, 32'h3, '0, 4'd7, 4'd0);
    tick();
    send_req(2'd0, 2'd0, 32'h40, '0, 4'd9, 4'd0);
    checks++;
    if (cyc !== 1 || resp_v !== 1) begin
      errors++; $display("FAIL rm_pre got cyc=%b v=%b want 1 1", cyc, resp_v);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (cyc !== 0 || stb !== 0 || resp_empty !== 1 || resp_v !== 0) begin
      errors++; $display("FAIL rm_async got cyc=%b stb=%b empty=%b v=%b want 0 0 1 0",
                         cyc, stb, resp_empty, resp_v);
    end
    tick();
    rst = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick(); tick();
    checks++;
    if (resp_empty !== 1 || req_rdy !== 1 || cyc !== 0) begin
      errors++; $display("FAIL rm_after got empty=%b rdy=%b cyc=%b want 1 1 0",
                         resp_empty, req_rdy, cyc);
    end
  endtask

  initial begin
    rst = 1'b1; req_v = 0; req_func = 0; req_sz = 0; req_adr = 0; req_dat = '0;
    req_rid = 0; req_step = 0; ack = 0; err = 0; dat_i = '0; resp_rd = 0;
    test_reset();
    test_byte_load();
    test_wyde_load();
    test_store_err();
    test_vect_store();
    test_misaligned();
    test_vect_err();
    test_fifo_full();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
